// File: rtl/ram128x18_fifo_ctrl.sv
// FIFO controller driving the 128x18 RAM macro write and read ports.
// Push/pop handshake, occupancy flags, sticky overflow/underflow errors.
module ram128x18_fifo_ctrl #(
   parameter int WORDSIZE = 18,
   parameter int ADDRBITS = 7,
   parameter int AF_LEVEL = 120,
   parameter int AE_LEVEL = 8
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_flush,
   input  logic                i_push,
   input  logic [WORDSIZE-1:0] i_push_data,
   input  logic                i_pop,
   output logic [WORDSIZE-1:0] o_pop_data,
   output logic                o_pop_valid,
   output logic                o_full,
   output logic                o_empty,
   output logic                o_almost_full,
   output logic                o_almost_empty,
   output logic [ADDRBITS:0]   o_count,
   output logic                o_overflow,
   output logic                o_underflow,
   input  logic                i_clr_err,
   output logic [ADDRBITS-1:0] o_ram_wa,
   output logic [WORDSIZE-1:0] o_ram_wd,
   output logic                o_ram_we,
   output logic [ADDRBITS-1:0] o_ram_ra,
   output logic                o_ram_re,
   output logic                o_ram_asyncrd,
   input  logic [WORDSIZE-1:0] i_ram_rd
);

   localparam int DEPTH = 2 ** ADDRBITS;
   localparam logic [ADDRBITS:0] C_DEPTH = (ADDRBITS + 1)'(DEPTH);
   localparam logic [ADDRBITS:0] C_AF    = (ADDRBITS + 1)'(AF_LEVEL);
   localparam logic [ADDRBITS:0] C_AE    = (ADDRBITS + 1)'(AE_LEVEL);

   logic [ADDRBITS-1:0] r_wptr;
   logic [ADDRBITS-1:0] r_rptr;
   logic [ADDRBITS:0]   r_count;
   logic                r_pop_valid;
   logic                r_af;
   logic                r_ae;
   logic                r_ovf;
   logic                r_udf;

   logic                w_full;
   logic                w_empty;
   logic                w_wr_ok;
   logic                w_rd_ok;
   logic                w_ovf_set;
   logic                w_udf_set;
   logic [ADDRBITS:0]   w_count_nxt;

   // Full/empty come only from the registered count.
   assign w_full    = (r_count == C_DEPTH);
   assign w_empty   = (r_count == '0);

   // A push into a full FIFO is dropped even if a pop frees a slot,
   // so the macro never sees a same-address write and read.
   assign w_wr_ok   = i_push & ~w_full  & ~i_flush;
   assign w_rd_ok   = i_pop  & ~w_empty & ~i_flush;
   assign w_ovf_set = i_push & w_full   & ~i_flush;
   assign w_udf_set = i_pop  & w_empty  & ~i_flush;

   // Next occupancy: flush clears, simultaneous push+pop cancels.
   always_comb begin
      w_count_nxt = r_count;
      if (i_flush) begin
         w_count_nxt = '0;
      end else if (w_wr_ok && !w_rd_ok) begin
         w_count_nxt = r_count + 1'b1;
      end else if (w_rd_ok && !w_wr_ok) begin
         w_count_nxt = r_count - 1'b1;
      end
   end

   // Pointers and count; pointers wrap naturally at 2**ADDRBITS.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         r_count <= w_count_nxt;
         if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
         end else begin
            if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
            if (w_rd_ok) r_rptr <= r_rptr + 1'b1;
         end
      end
   end

   // Occupancy flags track the count on the same edge.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_af <= 1'b0;
         r_ae <= 1'b1;
      end else begin
         r_af <= (w_count_nxt >= C_AF);
         r_ae <= (w_count_nxt <= C_AE);
      end
   end

   // Read strobe aligned with the macro's registered read address.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pop_valid <= 1'b0;
      end else begin
         r_pop_valid <= w_rd_ok;
      end
   end

   // Sticky errors; a new error outranks a same-cycle clear.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         r_ovf <= w_ovf_set | (r_ovf & ~i_clr_err);
         r_udf <= w_udf_set | (r_udf & ~i_clr_err);
      end
   end

   assign o_ram_we       = w_wr_ok;
   assign o_ram_wa       = r_wptr;
   assign o_ram_wd       = i_push_data;
   assign o_ram_re       = w_rd_ok;
   assign o_ram_ra       = r_rptr;
   assign o_ram_asyncrd  = 1'b0;

   assign o_pop_data     = i_ram_rd;
   assign o_pop_valid    = r_pop_valid;
   assign o_full         = w_full;
   assign o_empty        = w_empty;
   assign o_almost_full  = r_af;
   assign o_almost_empty = r_ae;
   assign o_count        = r_count;
   assign o_overflow     = r_ovf;
   assign o_underflow    = r_udf;

endmodule

// File: tb/tb_ram128x18_fifo_ctrl.sv
// Bench for ram128x18_fifo_ctrl with a behavioural 128x18 RAM macro.
// Scoreboard queue of expected pop data, checked as POP_VALID arrives.
module tb_ram128x18_fifo_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        push = 1'b0;
   logic        pop = 1'b0;
   logic        clr = 1'b0;
   logic [17:0] pdata = '0;

   logic [17:0] pop_data;
   logic        pop_valid;
   logic        full;
   logic        empty;
   logic        afull;
   logic        aempty;
   logic [7:0]  count;
   logic        ovf;
   logic        udf;
   logic [6:0]  ram_wa;
   logic [17:0] ram_wd;
   logic        ram_we;
   logic [6:0]  ram_ra;
   logic        ram_re;
   logic        ram_async;
   logic [17:0] ram_rd;

   int vecs = 0;
   int errs = 0;

   logic [17:0] m_q[$];
   logic [17:0] exp_q[$];
   bit          m_ovf = 1'b0;
   bit          m_udf = 1'b0;

   always #5 clk = ~clk;

   // Behavioural macro: synchronous write, registered read address.
   logic [17:0] mem [128];
   logic [6:0]  ra_q;
   always @(posedge clk) begin
      if (ram_we) mem[ram_wa] <= ram_wd;
      if (ram_re) ra_q <= ram_ra;
   end
   assign ram_rd = mem[ra_q];

   ram128x18_fifo_ctrl dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_flush        (flush),
      .i_push         (push),
      .i_push_data    (pdata),
      .i_pop          (pop),
      .o_pop_data     (pop_data),
      .o_pop_valid    (pop_valid),
      .o_full         (full),
      .o_empty        (empty),
      .o_almost_full  (afull),
      .o_almost_empty (aempty),
      .o_count        (count),
      .o_overflow     (ovf),
      .o_underflow    (udf),
      .i_clr_err      (clr),
      .o_ram_wa       (ram_wa),
      .o_ram_wd       (ram_wd),
      .o_ram_we       (ram_we),
      .o_ram_ra       (ram_ra),
      .o_ram_re       (ram_re),
      .o_ram_asyncrd  (ram_async),
      .i_ram_rd       (ram_rd)
   );

   // Drive one cycle, advance the model, return at posedge+1.
   task automatic tick(input bit ps, input logic [17:0] d,
                       input bit pp, input bit fl, input bit cl);
      bit wok;
      bit rok;
      push  = ps;
      pdata = d;
      pop   = pp;
      flush = fl;
      clr   = cl;
      wok   = ps && !fl && (m_q.size() < 128);
      rok   = pp && !fl && (m_q.size() > 0);
      m_ovf = (ps && !fl && m_q.size() == 128) || (m_ovf && !cl);
      m_udf = (pp && !fl && m_q.size() == 0) || (m_udf && !cl);
      if (fl) begin
         m_q.delete();
      end else begin
         if (rok) exp_q.push_back(m_q.pop_front());
         if (wok) m_q.push_back(d);
      end
      @(posedge clk);
      #1;
      push  = 1'b0;
      pop   = 1'b0;
      flush = 1'b0;
      clr   = 1'b0;
   endtask

   task automatic test_reset();
      vecs++;
      if ({count, empty, full, aempty, afull, pop_valid, ovf, udf, ram_async}
          !== {8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         errs++;
         $display("FAIL reset: cnt=%0d e=%b f=%b ae=%b af=%b pv=%b o=%b u=%b a=%b want 0 1 0 1 0 0 0 0 0",
                  count, empty, full, aempty, afull, pop_valid, ovf, udf, ram_async);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      vecs++;
      if (count !== 8'd0 || empty !== 1'b1) begin
         errs++;
         $display("FAIL reset_release: cnt=%0d e=%b want 0 1", count, empty);
      end
   endtask

   task automatic test_basic();
      logic [17:0] e;
      for (int i = 1; i <= 5; i++) tick(1, 18'(i), 0, 0, 0);
      vecs++;
      if (count !== 8'd5) begin
         errs++;
         $display("FAIL basic_count5: got %0d want 5", count);
      end
      for (int i = 0; i < 6; i++) begin
         tick(0, '0, i < 5, 0, 0);
         vecs++;
         if (pop_valid !== (exp_q.size() != 0)) begin
            errs++;
            $display("FAIL basic_pv[%0d]: got %b want %b", i, pop_valid, exp_q.size() != 0);
            exp_q.delete();
         end else if (pop_valid) begin
            e = exp_q.pop_front();
            vecs++;
            if (pop_data !== e) begin
               errs++;
               $display("FAIL basic_data[%0d]: got %h want %h", i, pop_data, e);
            end
         end
      end
      vecs++;
      if (count !== 8'd0 || empty !== 1'b1) begin
         errs++;
         $display("FAIL basic_end: cnt=%0d e=%b want 0 1", count, empty);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 128; i++) begin
         tick(1, 18'(i), 0, 0, 0);
         vecs++;
         if (count !== 8'(m_q.size()) || afull !== (m_q.size() >= 120)
             || full !== (m_q.size() == 128) || aempty !== (m_q.size() <= 8)) begin
            errs++;
            $display("FAIL fill[%0d]: cnt=%0d af=%b f=%b ae=%b want cnt=%0d", i,
                     count, afull, full, aempty, m_q.size());
         end
      end
      push  = 1'b1;
      pdata = 18'h3FFFF;
      #1;
      vecs++;
      if (ram_we !== 1'b0) begin
         errs++;
         $display("FAIL overflow_we: got %b want 0", ram_we);
      end
      tick(1, 18'h3FFFF, 0, 0, 0);
      vecs++;
      if (ovf !== 1'b1 || count !== 8'd128 || full !== 1'b1) begin
         errs++;
         $display("FAIL overflow: ovf=%b cnt=%0d f=%b want 1 128 1", ovf, count, full);
      end
      tick(0, '0, 0, 0, 1);
      vecs++;
      if (ovf !== 1'b0) begin
         errs++;
         $display("FAIL clr_ovf: got %b want 0", ovf);
      end
   endtask

   task automatic test_full_pushpop();
      logic [17:0] e;
      push  = 1'b1;
      pop   = 1'b1;
      pdata = 18'h15555;
      #1;
      vecs++;
      if (ram_we !== 1'b0 || ram_re !== 1'b1) begin
         errs++;
         $display("FAIL full_pp_ctrl: we=%b re=%b want 0 1", ram_we, ram_re);
      end
      tick(1, 18'h15555, 1, 0, 0);
      vecs++;
      if (count !== 8'd127 || ovf !== m_ovf || pop_valid !== 1'b1) begin
         errs++;
         $display("FAIL full_pp: cnt=%0d ovf=%b pv=%b want 127 1 1", count, ovf, pop_valid);
         exp_q.delete();
      end else begin
         e = exp_q.pop_front();
         vecs++;
         if (pop_data !== e) begin
            errs++;
            $display("FAIL full_pp_data: got %h want %h", pop_data, e);
         end
      end
   endtask

   task automatic test_empty_pushpop();
      logic [17:0] e;
      tick(0, '0, 0, 1, 0);
      push  = 1'b1;
      pop   = 1'b1;
      pdata = 18'h2AAAA;
      #1;
      vecs++;
      if (ram_re !== 1'b0 || ram_we !== 1'b1) begin
         errs++;
         $display("FAIL empty_pp_ctrl: re=%b we=%b want 0 1", ram_re, ram_we);
      end
      tick(1, 18'h2AAAA, 1, 0, 0);
      vecs++;
      if (udf !== 1'b1 || count !== 8'd1 || pop_valid !== 1'b0) begin
         errs++;
         $display("FAIL empty_pp: udf=%b cnt=%0d pv=%b want 1 1 0", udf, count, pop_valid);
      end
      tick(0, '0, 1, 0, 0);
      vecs++;
      if (pop_valid !== 1'b1) begin
         errs++;
         $display("FAIL empty_pp_pv: got %b want 1", pop_valid);
         exp_q.delete();
      end else begin
         e = exp_q.pop_front();
         vecs++;
         if (pop_data !== e) begin
            errs++;
            $display("FAIL empty_pp_data: got %h want %h", pop_data, e);
         end
      end
   endtask

   task automatic test_wrap();
      logic [17:0] e;
      for (int i = 0; i < 4; i++) tick(1, 18'(1000 + i), 0, 0, 0);
      for (int i = 0; i < 300; i++) begin
         tick(1, 18'(2000 + i), 1, 0, 0);
         vecs++;
         if (count !== 8'd4 || pop_valid !== (exp_q.size() != 0)) begin
            errs++;
            $display("FAIL wrap[%0d]: cnt=%0d pv=%b want 4 %b", i, count, pop_valid,
                     exp_q.size() != 0);
            exp_q.delete();
         end else if (pop_valid) begin
            e = exp_q.pop_front();
            if (pop_data !== e) begin
               errs++;
               $display("FAIL wrap_data[%0d]: got %h want %h", i, pop_data, e);
            end
         end
      end
      push  = 1'b1;
      flush = 1'b1;
      pdata = 18'h01234;
      #1;
      vecs++;
      if (ram_we !== 1'b0) begin
         errs++;
         $display("FAIL flush_we: got %b want 0", ram_we);
      end
      tick(1, 18'h01234, 0, 1, 0);
      vecs++;
      if (count !== 8'd0 || empty !== 1'b1 || pop_valid !== 1'b0 || aempty !== 1'b1) begin
         errs++;
         $display("FAIL flush: cnt=%0d e=%b pv=%b ae=%b want 0 1 0 1", count, empty,
                  pop_valid, aempty);
      end
      exp_q.delete();
      tick(1, 18'h00ABC, 0, 0, 0);
      tick(0, '0, 1, 0, 0);
      vecs++;
      if (pop_valid !== 1'b1 || pop_data !== 18'h00ABC) begin
         errs++;
         $display("FAIL post_flush: pv=%b data=%h want 1 00abc", pop_valid, pop_data);
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 51; i++) tick(1, 18'(i + 7), 0, 0, 0);
      tick(0, '0, 1, 0, 0);
      vecs++;
      if (count !== 8'd50 || pop_valid !== 1'b1 || udf !== 1'b1) begin
         errs++;
         $display("FAIL pre_rst: cnt=%0d pv=%b udf=%b want 50 1 1", count, pop_valid, udf);
      end
      rst = 1'b1;
      #1;
      vecs++;
      if ({count, empty, full, aempty, afull, pop_valid, ovf, udf}
          !== {8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         errs++;
         $display("FAIL mid_reset: cnt=%0d e=%b f=%b ae=%b af=%b pv=%b o=%b u=%b want 0 1 0 1 0 0 0 0",
                  count, empty, full, aempty, afull, pop_valid, ovf, udf);
      end
      m_q.delete();
      exp_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_clr_err();
      tick(0, '0, 1, 0, 0);
      vecs++;
      if (udf !== 1'b1) begin
         errs++;
         $display("FAIL udf_set: got %b want 1", udf);
      end
      tick(0, '0, 0, 0, 1);
      vecs++;
      if (udf !== 1'b0) begin
         errs++;
         $display("FAIL udf_clr: got %b want 0", udf);
      end
      tick(0, '0, 1, 0, 1);
      vecs++;
      if (udf !== m_udf || udf !== 1'b1) begin
         errs++;
         $display("FAIL set_wins: got %b want 1", udf);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_fill();
      test_full_pushpop();
      test_empty_pushpop();
      test_wrap();
      test_reset_mid();
      test_clr_err();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: sim still running at %0t", $time);
      $fatal(1);
   end

endmodule

// File: doc/ram128x18_fifo_ctrl.md
Name: ram128x18_fifo_ctrl

Overview:
- Synchronous FIFO controller placed directly upstream of the 128x18 RAM macro. It owns that macro's write and read ports.
- Converts a push/pop handshake into the macro's WA/WD/WE and RA/RE controls, and returns read data with a valid strobe.
- Tracks occupancy, full/empty and almost-full/almost-empty, and records overflow/underflow errors.
- Used as the AHB-side data buffer; the RAM's WCLK and RCLK are both tied to CLK at the instantiating level.

Parameters:
- WORDSIZE, 18, data width; must match the RAM macro.
- ADDRBITS, 7, pointer width; depth = 2**ADDRBITS = 128.
- AF_LEVEL, 120, COUNT at or above this value asserts ALMOST_FULL.
- AE_LEVEL, 8, COUNT at or below this value asserts ALMOST_EMPTY.

Ports:
- CLK  in  1  single clock for the controller and both RAM ports.
- RST  in  1  reset, asynchronous, active-high.
- FLUSH  in  1  synchronous clear of pointers and count.
- PUSH  in  1  write request.
- PUSH_DATA  in  WORDSIZE  write data.
- POP  in  1  read request.
- POP_DATA  out  WORDSIZE  read data; valid while POP_VALID=1.
- POP_VALID  out  1  one-cycle strobe, registered.
- FULL  out  1  COUNT == 128.
- EMPTY  out  1  COUNT == 0.
- ALMOST_FULL  out  1  registered occupancy flag.
- ALMOST_EMPTY  out  1  registered occupancy flag.
- COUNT  out  ADDRBITS+1  occupancy, 0..128.
- OVERFLOW  out  1  sticky error flag.
- UNDERFLOW  out  1  sticky error flag.
- CLR_ERR  in  1  clears the sticky error flags.
- RAM_WA  out  ADDRBITS  to RAM WA.
- RAM_WD  out  WORDSIZE  to RAM WD.
- RAM_WE  out  1  to RAM WE.
- RAM_RA  out  ADDRBITS  to RAM RA.
- RAM_RE  out  1  to RAM RE.
- RAM_ASYNCRD  out  1  to RAM ASYNCRD; constant 0.
- RAM_RD  in  WORDSIZE  from RAM RD.

Behaviour:
- Reset (RST=1, asynchronous): write pointer wptr=0, read pointer rptr=0, COUNT=0, EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0, POP_VALID=0, OVERFLOW=0, UNDERFLOW=0.
- Accepted write: wr_ok = PUSH & ~FULL & ~FLUSH.
- Accepted read: rd_ok = POP & ~EMPTY & ~FLUSH.
- FULL and EMPTY come from the registered COUNT, never from the same-cycle request.
- RAM write side, combinational:
  - RAM_WE = wr_ok.
  - RAM_WA = wptr.
  - RAM_WD = PUSH_DATA.
- RAM read side, combinational:
  - RAM_RE = rd_ok.
  - RAM_RA = rptr.
- RAM_ASYNCRD = 0. The read address is registered inside the macro, so RAM_RD reflects mem[rptr_old] after the edge.
- Read latency: POP accepted at edge k gives POP_VALID=1 during cycle k..k+1, with POP_DATA = RAM_RD.
- POP_VALID is a flop: POP_VALID <= rd_ok.
- POP_DATA holds its last value after POP_VALID drops, because the macro's address register holds.
- Pointers: wptr increments on wr_ok and rptr on rd_ok, modulo 128 (127 -> 0 wrap, no extra wrap bit; COUNT disambiguates full from empty).
- COUNT update:
  - +1 on wr_ok only.
  - -1 on rd_ok only.
  - Unchanged when both or neither fire.
- ALMOST_FULL and ALMOST_EMPTY are registered from the next-state COUNT, so they change on the same edge as COUNT.
- Full boundary: PUSH while FULL=1 is dropped, even if POP is asserted in the same cycle. This avoids a same-address write/read hazard in the macro. OVERFLOW is set. A POP in that cycle is still accepted.
- Empty boundary: POP while EMPTY=1 is dropped, even if PUSH is asserted in the same cycle. No RAM_RE and no POP_VALID are issued. UNDERFLOW is set. A PUSH in that cycle is still accepted.
- FLUSH has priority over PUSH and POP. At the edge: wptr=rptr=0, COUNT=0, POP_VALID=0. Error flags are unaffected. A FLUSH at the same edge as an in-flight POP_VALID forces POP_VALID to 0 in the next cycle.
- Error flags: OVERFLOW and UNDERFLOW are sticky. CLR_ERR clears them; if a new error occurs in the same cycle as CLR_ERR, the set wins.
- RST mid-operation: all state returns to reset values immediately. RAM contents are not cleared, and data after reset is treated as invalid.
- Arithmetic: COUNT is ADDRBITS+1 bits wide; it must never exceed 128 or wrap below 0.

Test Plan:
- Reset, then push 0x00001..0x00005 on consecutive cycles, then pop 5 -> POP_VALID pulses for 5 consecutive cycles, each one cycle after its pop. POP_DATA = 0x00001..0x00005 in order. COUNT goes 0→5→0 and EMPTY=1 at the end.
- Push 128 words (value = index) -> FULL=1 and COUNT=128; ALMOST_FULL first asserts when COUNT=120. A 129th push with data 0x3FFFF -> ignored, OVERFLOW=1, and RAM_WE stays 0.
- FULL with PUSH and POP together -> only the pop is accepted: COUNT=127, OVERFLOW=1, popped data = 0x00000.
- EMPTY with PUSH (0x2AAAA) and POP together -> pop dropped, UNDERFLOW=1, COUNT=1, no POP_VALID. The next pop returns 0x2AAAA.
- Wrap test: push and pop 300 words in steady-state with occupancy 4 -> data order is preserved across the wptr/rptr 127→0 wraps and COUNT stays 4. Then FLUSH together with PUSH -> COUNT=0, EMPTY=1, and the push is not written.
- Assert RST while COUNT=50 and a POP_VALID is in flight -> all outputs return to reset values within the same cycle. Then CLR_ERR after an error -> the flag clears on the next edge.
